// File: rtl/multi_strobe_gen.sv
// Multi-channel delayed-strobe generator: one event edge (or a per-channel software trigger)
// launches independent delay/width/polarity pulses, plus a one-cycle npiRst per event edge.
module multi_strobe_gen #(
   parameter int N_CH  = 4,
   parameter int CNT_W = 32
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  myEvent,
   input  logic [N_CH-1:0]       enable,
   input  logic [N_CH-1:0]       sw_trig,
   input  logic [N_CH*CNT_W-1:0] myDelay,
   input  logic [N_CH*CNT_W-1:0] myWidth,
   input  logic [N_CH-1:0]       polarity,
   input  logic                  clr_ovr,
   output logic [N_CH-1:0]       trigger,
   output logic [N_CH-1:0]       busy,
   output logic [N_CH-1:0]       overrun,
   output logic                  npiRst
);

   typedef enum logic [1:0] {IDLE, DELAY, PULSE} chState_t;

   logic            evtPrev;
   logic            evtEdgeQ;
   logic [N_CH-1:0] req;
   logic [N_CH-1:0] pulseActive;

   // evtPrev resets high so a level held across reset is not mistaken for an edge.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         evtPrev  <= 1'b1;
         evtEdgeQ <= 1'b0;
         npiRst   <= 1'b0;
         req      <= '0;
      end else begin
         evtPrev  <= myEvent;
         evtEdgeQ <= myEvent & ~evtPrev;
         npiRst   <= evtEdgeQ;
         req      <= sw_trig | {N_CH{evtEdgeQ}};
      end
   end

   for (genvar i = 0; i < N_CH; i++) begin : gCh
      chState_t         state;
      logic [CNT_W-1:0] cnt;
      logic [CNT_W-1:0] widthQ;
      logic [CNT_W-1:0] dIn;
      logic [CNT_W-1:0] wIn;
      logic             accept;
      logic             busyQ;
      logic             pulseQ;
      logic             ovrQ;

      assign dIn    = myDelay[i*CNT_W +: CNT_W];
      assign wIn    = myWidth[i*CNT_W +: CNT_W];
      assign accept = req[i] & enable[i];

      always_ff @(posedge Clock) begin
         if (Reset) begin
            state  <= IDLE;
            cnt    <= '0;
            widthQ <= '0;
            busyQ  <= 1'b0;
            pulseQ <= 1'b0;
            ovrQ   <= 1'b0;
         end else begin
            if (accept && (state != IDLE))
               ovrQ <= 1'b1;
            else if (clr_ovr)
               ovrQ <= 1'b0;

            // cnt holds the cycles remaining in the current phase, so it only ever counts down.
            case (state)
               IDLE: begin
                  if (accept && (dIn != '0) && (wIn != '0)) begin
                     state  <= DELAY;
                     cnt    <= dIn;
                     widthQ <= wIn;
                     busyQ  <= 1'b1;
                  end
               end
               DELAY: begin
                  if (!enable[i]) begin
                     state <= IDLE;
                     cnt   <= '0;
                     busyQ <= 1'b0;
                  end else if (cnt == CNT_W'(1)) begin
                     state  <= PULSE;
                     cnt    <= widthQ;
                     pulseQ <= 1'b1;
                  end else begin
                     cnt <= cnt - CNT_W'(1);
                  end
               end
               PULSE: begin
                  if (!enable[i] || (cnt == CNT_W'(1))) begin
                     state  <= IDLE;
                     cnt    <= '0;
                     busyQ  <= 1'b0;
                     pulseQ <= 1'b0;
                  end else begin
                     cnt <= cnt - CNT_W'(1);
                  end
               end
               default: begin
                  state  <= IDLE;
                  cnt    <= '0;
                  busyQ  <= 1'b0;
                  pulseQ <= 1'b0;
               end
            endcase
         end
      end

      assign busy[i]        = busyQ;
      assign pulseActive[i] = pulseQ;
      assign overrun[i]     = ovrQ;
   end

   assign trigger = pulseActive ^ polarity;

endmodule

// File: doc/multi_strobe_gen.md
# multi_strobe_gen

Parametrised multi-channel delayed-strobe generator for the NPI acquisition path. One common event input produces up to N_CH independent output pulses. Each pulse has its own delay, width and polarity, and there is a per-channel software trigger and overrun reporting. It also emits a one-cycle NPI reset pulse on every event rising edge, and it replaces the single-channel strobe generator wherever more than one timed strobe is needed.

## Interface
Parameters:
- N_CH, 4, number of channels (1..16)
- CNT_W, 32, width of the delay/width fields and counters

Ports:
- Clock  in  1  system clock; all logic on rising edge
- Reset  in  1  reset Reset, synchronous, active-high; clock Clock
- myEvent  in  1  common event, asynchronous-level-safe only if pre-synchronised upstream; rising edge is the trigger
- enable  in  N_CH  per-channel enable
- sw_trig  in  N_CH  per-channel single-cycle software trigger
- myDelay  in  N_CH*CNT_W  packed delays; channel i = bits [i*CNT_W +: CNT_W]
- myWidth  in  N_CH*CNT_W  packed widths, same packing
- polarity  in  N_CH  0 = active-high pulse, 1 = active-low pulse
- clr_ovr  in  1  clears all overrun flags
- trigger  out  N_CH  strobe outputs
- busy  out  N_CH  channel in DELAY or PULSE
- overrun  out  N_CH  sticky: trigger arrived while busy
- npiRst  out  1  one-cycle pulse per event rising edge

## Operation
- Edge detect: a registered copy of myEvent is kept. evt_edge = myEvent & ~prev. npiRst is evt_edge registered, so it is high for exactly one cycle.
- Channel trigger request: req[i] = npiRst | sw_trig[i], registered alongside npiRst so that both sources align.
- Per-channel FSM has three states: IDLE, DELAY, PULSE.
- IDLE → DELAY on req[i] & enable[i], when the sampled myDelay ≠ 0 and myWidth ≠ 0.
  - At that point D and W are latched into channel shadow registers.
  - Later input changes do not affect the pulse in flight.
- req with D = 0 or W = 0 means no pulse, the FSM stays IDLE and overrun is not set.
- DELAY: counter counts D cycles, then the FSM moves to PULSE.
- PULSE: counter counts W cycles, then the FSM moves to IDLE.
- Counters are CNT_W bits and never wrap; the maximum D or W is 2^CNT_W − 1.
- Overrun: when req[i] & enable[i] arrives while busy[i], the request is ignored, the running pulse continues and overrun[i] is set.
  - clr_ovr clears all overrun bits.
  - A set and a clear in the same cycle leave the bit set.
- Disabling a channel (enable[i] = 0) in DELAY or PULSE aborts it. The FSM is IDLE and trigger is inactive on the next cycle.
- npiRst and sw_trig in the same cycle produce one acceptance only.
- trigger[i] = pulse_active[i] XOR polarity[i]. The idle level therefore equals polarity[i].
- busy[i] = 1 in DELAY or PULSE.

## Timing
- Reset: all FSMs IDLE and counters 0; npiRst = 0, busy = 0, overrun = 0; trigger = polarity (inactive level).
- Cycle numbering: edge E is the first Clock edge that samples myEvent = 1 after sampling 0.
  - npiRst is high in cycle E+1 only.
  - The channel accepts at edge E+2.
  - pulse_active is high for cycles E+2+D … E+1+D+W, i.e. exactly W cycles.
  - Fixed latency from the event edge to the leading edge of trigger is D+2 cycles. A sw_trig sampled at edge S gives a leading edge at S+1+D.
- busy is high from E+2 through the last pulse cycle and is low on the cycle after.
- The earliest retrigger accepted without overrun is a req registered on the first IDLE cycle after the pulse ends.
- Reset asserted mid-operation returns the block to reset values on the next edge. A myEvent held high across reset deassertion does not generate an edge until it has first been sampled low.
- Edge detection and all state/control logic is registered; trigger adds only the polarity XOR after the register.

## Test plan
- N_CH=4, ch0 D=5 W=3 pol=0: myEvent 0→1 at edge E → npiRst high cycle E+1 only; trigger[0] high cycles E+7..E+9; busy[0] high E+2..E+9.
- ch1 pol=1 D=1 W=1, ch2 D=0 W=4: event → trigger[1] low for exactly 1 cycle at E+3 and otherwise high; trigger[2] stays inactive, busy[2] stays 0.
- ch0 D=10 W=10: second event at E+8 → pulse unchanged; overrun[0]=1; clr_ovr pulse → overrun[0]=0.
- sw_trig[3] at S with D=2 W=2 → trigger[3] high S+3..S+4; npiRst stays 0; no other channel fires.
- ch0 in PULSE, enable[0] dropped → trigger[0] inactive next cycle, busy[0]=0. Separately, Reset during DELAY → all outputs at reset values next cycle.
- myDelay changed from 5 to 50 during DELAY → pulse timing still uses 5; the next event uses 50.
